// File: rtl/tjmono_rx_pkg.sv
// Shared definitions for the TJ-Monopix RX path.
// Covers the FIFO word layout, the hit record field map and the
// hit assembler state encoding.
package tjmono_rx_pkg;

    // FIFO word layout: [31:30] channel ID, [29:28] word index, [27:0] payload
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned PAYLOAD_W = 28;
    localparam int unsigned REC_W     = 3 * PAYLOAD_W;  // 84-bit hit record

    // Word index of each of the four words that make up a hit
    localparam logic [1:0] IDX_W0 = 2'b00;
    localparam logic [1:0] IDX_W1 = 2'b01;
    localparam logic [1:0] IDX_W2 = 2'b10;
    localparam logic [1:0] IDX_W3 = 2'b11;

    // Field offsets and widths inside the 84-bit record
    localparam int unsigned COL_LSB    = 0;
    localparam int unsigned COL_W      = 6;
    localparam int unsigned ROW_LSB    = 6;
    localparam int unsigned ROW_W      = 9;
    localparam int unsigned TE_LSB     = 15;
    localparam int unsigned TE_W       = 6;
    localparam int unsigned LE_LSB     = 21;
    localparam int unsigned LE_W       = 6;
    localparam int unsigned NOISE_BIT  = 27;
    localparam int unsigned TS_LSB     = 28;
    localparam int unsigned TS_W       = 52;
    localparam int unsigned TOKCNT_LSB = 80;
    localparam int unsigned TOKCNT_W   = 4;

    // Assembler state: the index of the word expected next
    typedef enum logic [1:0] {
        W0 = IDX_W0,
        W1 = IDX_W1,
        W2 = IDX_W2,
        W3 = IDX_W3
    } asm_state_e;

endpackage

// File: rtl/tjmono_hit_unpack.sv
// Combinational split of an 84-bit hit record into its fields.
// Also derives time-over-threshold as (TE - LE) modulo 64.
module tjmono_hit_unpack
    import tjmono_rx_pkg::*;
(
    input  logic [REC_W-1:0]    rec_i,
    output logic [COL_W-1:0]    col_o,
    output logic [ROW_W-1:0]    row_o,
    output logic [TE_W-1:0]     te_o,
    output logic [LE_W-1:0]     le_o,
    output logic [TE_W-1:0]     tot_o,
    output logic                noise_o,
    output logic [TS_W-1:0]     ts_o,
    output logic [TOKCNT_W-1:0] token_cnt_o
);

    assign col_o       = rec_i[COL_LSB    +: COL_W];
    assign row_o       = rec_i[ROW_LSB    +: ROW_W];
    assign te_o        = rec_i[TE_LSB     +: TE_W];
    assign le_o        = rec_i[LE_LSB     +: LE_W];
    assign noise_o     = rec_i[NOISE_BIT];
    assign ts_o        = rec_i[TS_LSB     +: TS_W];
    assign token_cnt_o = rec_i[TOKCNT_LSB +: TOKCNT_W];

    // Both operands are 6 bits wide, so the subtraction wraps naturally
    assign tot_o = te_o - le_o;

endmodule

// File: rtl/tjmono_hit_assembler.sv
// Pops 32-bit words from the RX core FIFO and rebuilds 4-word hit records.
// Presents each hit over a valid/ready handshake and counts index-order
// and channel-ID errors.
module tjmono_hit_assembler
    import tjmono_rx_pkg::*;
#(
    parameter logic [1:0]  IDENTIFIER = 2'b00,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              BUS_CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_READ,
    input  logic [WORD_W-1:0] FIFO_DATA,
    output logic              HIT_VALID,
    input  logic              HIT_READY,
    output logic [5:0]        HIT_COL,
    output logic [8:0]        HIT_ROW,
    output logic [5:0]        HIT_TE,
    output logic [5:0]        HIT_LE,
    output logic [5:0]        HIT_TOT,
    output logic              HIT_NOISE,
    output logic [51:0]       HIT_TS,
    output logic [3:0]        HIT_TOKEN_CNT,
    output logic [31:0]       HIT_CNT,
    output logic [CNT_W-1:0]  SEQ_ERR_CNT,
    output logic [CNT_W-1:0]  ID_ERR_CNT
);

    asm_state_e          state_q, state_d;
    logic                rd_pending_q;
    logic [REC_W-1:0]    part_q, part_d;      // hit under construction
    logic [REC_W-1:0]    rec_q, rec_d;        // hit on the output
    logic                hit_valid_q, hit_valid_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    seq_err_q, seq_err_d;
    logic [CNT_W-1:0]    id_err_q, id_err_d;

    logic [1:0]           word_id;
    logic [1:0]           word_idx;
    logic [PAYLOAD_W-1:0] payload;
    logic                 accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign word_id  = FIFO_DATA[31:30];
    assign word_idx = FIFO_DATA[29:28];
    assign payload  = FIFO_DATA[PAYLOAD_W-1:0];
    assign accept   = hit_valid_q & HIT_READY;

    // Pop only when the output can take a completion. Never pop behind a
    // word that may complete a hit, so at most one completion is in flight.
    assign FIFO_READ = !RST & EN & !FIFO_EMPTY & (!hit_valid_q | HIT_READY)
                     & !(rd_pending_q & (state_q == W3));

    // Next-state: handshake bookkeeping, then processing of the sampled word
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch)
        state_d     = state_q;
        part_d      = part_q;
        rec_d       = rec_q;
        hit_valid_d = hit_valid_q;
        hit_cnt_d   = hit_cnt_q;
        seq_err_d   = seq_err_q;
        id_err_d    = id_err_q;

        if (accept) begin
            hit_valid_d = 1'b0;
            hit_cnt_d   = hit_cnt_q + 32'd1;
        end

        if (rd_pending_q) begin
            if (word_id != IDENTIFIER) begin
                id_err_d = sat_inc(id_err_q);
            end else if (word_idx == state_q) begin
                case (state_q)
                    W0: begin
                        part_d[0 +: PAYLOAD_W] = payload;
                        state_d = W1;
                    end
                    W1: begin
                        part_d[PAYLOAD_W +: PAYLOAD_W] = payload;
                        state_d = W2;
                    end
                    W2: begin
                        part_d[2*PAYLOAD_W +: PAYLOAD_W] = payload;
                        state_d = W3;
                    end
                    W3: begin
                        // Last word carries no record bits; the output is free here
                        rec_d       = part_q;
                        hit_valid_d = 1'b1;
                        state_d     = W0;
                    end
                endcase
            end else begin
                seq_err_d = sat_inc(seq_err_q);
                if (word_idx == IDX_W0) begin
                    part_d[0 +: PAYLOAD_W] = payload;
                    state_d = W1;
                end else begin
                    state_d = W0;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge BUS_CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values
        if (RST) begin
            // NOTE: record registers are cleared too, so outputs read 0 and stale partials are discarded
            state_q      <= W0;
            rd_pending_q <= 1'b0;
            part_q       <= '0;
            rec_q        <= '0;
            hit_valid_q  <= 1'b0;
            hit_cnt_q    <= '0;
            seq_err_q    <= '0;
            id_err_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= FIFO_READ;
            part_q       <= part_d;
            rec_q        <= rec_d;
            hit_valid_q  <= hit_valid_d;
            hit_cnt_q    <= hit_cnt_d;
            seq_err_q    <= seq_err_d;
            id_err_q     <= id_err_d;
        end
    end

    tjmono_hit_unpack u_unpack (
        .rec_i       (rec_q),
        .col_o       (HIT_COL),
        .row_o       (HIT_ROW),
        .te_o        (HIT_TE),
        .le_o        (HIT_LE),
        .tot_o       (HIT_TOT),
        .noise_o     (HIT_NOISE),
        .ts_o        (HIT_TS),
        .token_cnt_o (HIT_TOKEN_CNT)
    );

    assign HIT_VALID   = hit_valid_q;
    assign HIT_CNT     = hit_cnt_q;
    assign SEQ_ERR_CNT = seq_err_q;
    assign ID_ERR_CNT  = id_err_q;

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Directed bench for tjmono_hit_assembler: FIFO model feeding words,
// a monitor capturing accepted hits, hand-computed expectations.
module tb_tjmono_hit_assembler;

    logic        BUS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        FIFO_EMPTY;
    logic        FIFO_READ;
    logic [31:0] FIFO_DATA = '0;
    logic        HIT_VALID;
    logic        HIT_READY = 1'b0;
    logic [5:0]  HIT_COL;
    logic [8:0]  HIT_ROW;
    logic [5:0]  HIT_TE;
    logic [5:0]  HIT_LE;
    logic [5:0]  HIT_TOT;
    logic        HIT_NOISE;
    logic [51:0] HIT_TS;
    logic [3:0]  HIT_TOKEN_CNT;
    logic [31:0] HIT_CNT;
    logic [7:0]  SEQ_ERR_CNT;
    logic [7:0]  ID_ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;

    tjmono_hit_assembler #(.IDENTIFIER(2'b00), .CNT_W(8)) dut (
        .BUS_CLK       (BUS_CLK),
        .RST           (RST),
        .EN            (EN),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .FIFO_READ     (FIFO_READ),
        .FIFO_DATA     (FIFO_DATA),
        .HIT_VALID     (HIT_VALID),
        .HIT_READY     (HIT_READY),
        .HIT_COL       (HIT_COL),
        .HIT_ROW       (HIT_ROW),
        .HIT_TE        (HIT_TE),
        .HIT_LE        (HIT_LE),
        .HIT_TOT       (HIT_TOT),
        .HIT_NOISE     (HIT_NOISE),
        .HIT_TS        (HIT_TS),
        .HIT_TOKEN_CNT (HIT_TOKEN_CNT),
        .HIT_CNT       (HIT_CNT),
        .SEQ_ERR_CNT   (SEQ_ERR_CNT),
        .ID_ERR_CNT    (ID_ERR_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Upstream FIFO model: written by the stimulus, popped with 1-cycle latency
    logic [31:0] fifo_mem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);

    always @(posedge BUS_CLK) begin
        if (FIFO_READ) begin
            FIFO_DATA <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Hit monitor: a hit seen valid&ready at the falling edge is accepted at the next rising edge
    typedef struct {
        logic [5:0]  col;
        logic [8:0]  row;
        logic [5:0]  te;
        logic [5:0]  le;
        logic [5:0]  tot;
        logic        noise;
        logic [51:0] ts;
        logic [3:0]  tok;
    } hit_t;

    hit_t cap [0:63];
    int   cap_n = 0;

    always @(negedge BUS_CLK) begin
        if (!RST && HIT_VALID && HIT_READY && cap_n < 64) begin
            cap[cap_n] <= '{HIT_COL, HIT_ROW, HIT_TE, HIT_LE, HIT_TOT,
                            HIT_NOISE, HIT_TS, HIT_TOKEN_CNT};
            cap_n <= cap_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge BUS_CLK);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_hits(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && cap_n < target; i++) tick();
        tick();
        check(tag, 64'(cap_n), 64'(target));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && rd_ptr != wr_ptr; i++) tick();
        tick(3);
        check(tag, 64'(rd_ptr), 64'(wr_ptr));
    endtask

    int base;

    initial begin
        // ---------------- reset state ----------------
        tick(3);
        check("rst_valid",   64'(HIT_VALID), 64'd0);
        check("rst_read",    64'(FIFO_READ), 64'd0);
        check("rst_hitcnt",  64'(HIT_CNT), 64'd0);
        check("rst_seqerr",  64'(SEQ_ERR_CNT), 64'd0);
        check("rst_iderr",   64'(ID_ERR_CNT), 64'd0);
        check("rst_col",     64'(HIT_COL), 64'd0);
        RST = 1'b0;
        EN  = 1'b1;
        HIT_READY = 1'b1;
        tick(2);

        // ---------------- test 1: one clean hit ----------------
        push(32'h00ABCDEF);
        push(32'h10000123);
        push(32'h20000045);
        push(32'h30000000);
        wait_hits("t1_hits", 1, 50);
        check("t1_col",   64'(cap[0].col), 64'h2F);
        check("t1_row",   64'(cap[0].row), 64'h137);
        check("t1_te",    64'(cap[0].te), 64'h17);
        check("t1_le",    64'(cap[0].le), 64'h05);
        check("t1_tot",   64'(cap[0].tot), 64'h12);
        check("t1_noise", 64'(cap[0].noise), 64'd0);
        check("t1_ts",    64'(cap[0].ts), 64'h450000123);
        check("t1_tok",   64'(cap[0].tok), 64'h0);
        tick(2);
        check("t1_hitcnt", 64'(HIT_CNT), 64'd1);
        check("t1_valid",  64'(HIT_VALID), 64'd0);
        check("t1_seqerr", 64'(SEQ_ERR_CNT), 64'd0);
        check("t1_iderr",  64'(ID_ERR_CNT), 64'd0);

        // ---------------- test 2: backpressure ----------------
        HIT_READY = 1'b0;
        push(32'h00ABCDEF);
        push(32'h10000123);
        push(32'h20000045);
        push(32'h30000000);
        push(32'h00000001);
        push(32'h10000000);
        push(32'h20000000);
        push(32'h30000000);
        for (int i = 0; i < 50 && !HIT_VALID; i++) tick();
        check("t2_valid_up", 64'(HIT_VALID), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge BUS_CLK);
            check("t2_hold_valid", 64'(HIT_VALID), 64'd1);
            check("t2_hold_read",  64'(FIFO_READ), 64'd0);
            check("t2_hold_col",   64'(HIT_COL), 64'h2F);
            check("t2_hold_ts",    64'(HIT_TS), 64'h450000123);
        end
        tick();
        check("t2_fifo_level", 64'(wr_ptr - rd_ptr), 64'd4);
        HIT_READY = 1'b1;
        wait_hits("t2_hits", 3, 60);
        check("t2_col_a", 64'(cap[1].col), 64'h2F);
        check("t2_row_a", 64'(cap[1].row), 64'h137);
        check("t2_col_b", 64'(cap[2].col), 64'h01);
        check("t2_ts_b",  64'(cap[2].ts), 64'h0);
        tick(2);
        check("t2_drained", 64'(rd_ptr), 64'(wr_ptr));
        check("t2_hitcnt",  64'(HIT_CNT), 64'd3);

        // ---------------- test 3: index order error ----------------
        push(32'h00000011);
        push(32'h10000000);
        push(32'h00000022);
        push(32'h10000000);
        push(32'h20000000);
        push(32'h30000000);
        wait_hits("t3_hits", 4, 60);
        check("t3_col",    64'(cap[3].col), 64'h22);
        tick(2);
        check("t3_seqerr", 64'(SEQ_ERR_CNT), 64'd1);
        check("t3_hitcnt", 64'(HIT_CNT), 64'd4);

        // ---------------- test 4: foreign-ID word ----------------
        push(32'h00000033);
        push(32'h10000456);
        push(32'h40000000);
        push(32'h20000000);
        push(32'h30000000);
        wait_hits("t4_hits", 5, 60);
        check("t4_col",    64'(cap[4].col), 64'h33);
        check("t4_ts",     64'(cap[4].ts), 64'h456);
        tick(2);
        check("t4_iderr",  64'(ID_ERR_CNT), 64'd1);
        check("t4_seqerr", 64'(SEQ_ERR_CNT), 64'd1);
        check("t4_hitcnt", 64'(HIT_CNT), 64'd5);

        // ---------------- test 5: TOT wrap, noise, token, saturation ----------------
        push(32'h0F810000);
        push(32'h1FFFFFFF);
        push(32'h2A000000);
        push(32'h30000000);
        wait_hits("t5_hits", 6, 60);
        check("t5_te",    64'(cap[5].te), 64'd2);
        check("t5_le",    64'(cap[5].le), 64'd60);
        check("t5_tot",   64'(cap[5].tot), 64'd6);
        check("t5_noise", 64'(cap[5].noise), 64'd1);
        check("t5_tok",   64'(cap[5].tok), 64'hA);
        check("t5_ts",    64'(cap[5].ts), 64'hFFFFFFF);
        for (int i = 0; i < 300; i++) push(32'h10000000);
        wait_drain("t5_drain", 1000);
        check("t5_seqsat", 64'(SEQ_ERR_CNT), 64'd255);
        check("t5_hitcnt", 64'(HIT_CNT), 64'd6);

        // ---------------- test 6: reset with a read in flight ----------------
        base = wr_ptr;
        push(32'h00000005);
        push(32'h10000000);
        for (int i = 0; i < 50 && rd_ptr != base + 2; i++) tick();
        check("t6_popped", 64'(rd_ptr), 64'(base + 2));
        RST = 1'b1;
        tick(2);
        @(negedge BUS_CLK);
        check("t6_valid",  64'(HIT_VALID), 64'd0);
        check("t6_read",   64'(FIFO_READ), 64'd0);
        check("t6_hitcnt", 64'(HIT_CNT), 64'd0);
        check("t6_seqerr", 64'(SEQ_ERR_CNT), 64'd0);
        check("t6_iderr",  64'(ID_ERR_CNT), 64'd0);
        check("t6_col",    64'(HIT_COL), 64'd0);
        check("t6_ts",     64'(HIT_TS), 64'd0);
        tick();
        RST = 1'b0;
        push(32'h00000015);
        push(32'h10000000);
        push(32'h20000000);
        push(32'h30000000);
        wait_hits("t6_hits", 7, 60);
        check("t6_new_col", 64'(cap[6].col), 64'h15);
        tick(10);
        check("t6_one_hit",   64'(cap_n), 64'd7);
        check("t6_hitcnt_1",  64'(HIT_CNT), 64'd1);
        check("t6_seqerr_0",  64'(SEQ_ERR_CNT), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
